fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage ARM pipeline: owns the PC, addresses instruction memory, and loads the IF/ID latch.
//   Feeds the control unit in ID. Handles hazard stalls, taken-branch redirect/squash and frontend freeze.
//   Small fetch FSM and a saturating fetched-instruction counter for debug.
// PARAMETERS
//   ADDR_W    8             instruction-memory byte-address width (imem_addr = PC[ADDR_W-1:0])
//   RESET_PC  32'h0000_0000 PC value loaded by reset
//   NOP_WORD  32'h0000_0000 bubble instruction inserted into IF/ID (decodes as NOP)
// PORTS
//   clk              in   1       clock, all state updates on rising edge
//   reset            in   1       synchronous, active-high
//   pc_enable        in   1       frontend enable; 0 = freeze PC, drain bubbles
//   stall            in   1       hazard-unit stall: hold PC and IF/ID
//   branch_taken     in   1       ID-stage PCSrc: redirect fetch this cycle
//   branch_target    in   32      redirect address (byte address)
//   imem_addr        out  ADDR_W  combinational: PC[ADDR_W-1:0]
//   imem_data        in   32      combinational instruction read for imem_addr
//   pc_current       out  32      current PC register
//   if_id_instr      out  32      IF/ID instruction to control unit
//   if_id_pc_plus_4  out  32      IF/ID PC+4 of that instruction
//   if_id_valid      out  1       1 = if_id_instr is a real fetch, 0 = bubble
//   fetch_state      out  2       registered FSM state: 00 RUN, 01 STALL, 10 FLUSH, 11 IDLE
//   fetch_count      out  32      real instructions loaded into IF/ID, saturating
// BEHAVIOUR
//   - Reset (sync, high) outputs: pc_current=RESET_PC; if_id_instr=NOP_WORD; if_id_pc_plus_4=0; if_id_valid=0;
//     fetch_state=IDLE; fetch_count=0.
//   - Reset has top priority. A reset asserted mid-stall or mid-redirect discards the action in the same edge.
//   - Per-edge priority: reset > branch_taken > stall > !pc_enable > normal.
//   - Normal: PC<=PC+4; IF/ID<={imem_data, PC+4}; valid<=1; count+=1; state<=RUN.
//   - stall=1: PC, IF/ID, valid and count hold; state<=STALL. Stall may last any number of cycles.
//   - branch_taken=1 (stall ignored): PC<={branch_target[31:2],2'b00}; state<=FLUSH.
//     The fetched instruction is squashed: IF/ID<={NOP_WORD, PC+4}; valid<=0; count holds.
//   - !pc_enable: PC holds; IF/ID<={NOP_WORD, PC+4}; valid<=0; count holds; state<=IDLE.
//   - First post-reset edge with pc_enable=1 fetches RESET_PC. Latency: PC to IF/ID = 1 cycle; redirect to first target instruction in IF/ID = 1 cycle.
//   - Arithmetic: PC+4 wraps modulo 2^32. imem_addr truncates, so fetch wraps at 2^ADDR_W bytes.
//     fetch_count saturates at 32'hFFFF_FFFF.
//   - imem_addr is purely combinational from the PC register. No combinational path from stall or branch_* to imem_addr.
// CONFIGURATION
//   FETCH_DELAY_SLOT_EN defined: on branch_taken the current fetch is kept as a delay slot:
//     IF/ID<={imem_data, PC+4}; valid<=1; count+=1; state<=FLUSH. PC redirect is unchanged.
//   Undefined (default): squash as above, so a taken branch costs one bubble.
// STRUCTURE
//   Shared package fetch_pkg: fetch_state_t enum (RUN/STALL/FLUSH/IDLE), PC_STEP=32'd4, NOP_WORD default.
//   Sub-module fetch_ctrl contains the priority decode and the FSM.
//     Outputs: pc_sel (incr/hold/target), ifid_load, ifid_bubble, cnt_inc.
//     Datapath (PC reg, IF/ID regs, counter) stays in fetch_stage. PC+4 uses the existing adder module.
// TESTING
//   1. reset 3 cycles, then pc_enable=1, imem[0,4,8] preloaded -> pc_current 0,4,8,12.
//      if_id_instr follows one cycle later; if_id_pc_plus_4=4,8,12; valid=1; fetch_count=1,2,3.
//   2. PC=8, stall=1 for 3 cycles -> pc_current stays 8 and IF/ID frozen. fetch_state=STALL.
//      First edge after release: PC=12.
//   3. PC=12, branch_taken=1, target=32'h23 -> PC=32'h20; fetch_state=FLUSH.
//      No macro: if_id_instr=0, valid=0. With FETCH_DELAY_SLOT_EN: if_id_instr=imem[12], valid=1.
//   4. stall=1 and branch_taken=1 same edge -> redirect taken as in 3; stall ignored.
//   5. pc_enable=0 for 2 cycles at PC=16 -> PC stays 16; IF/ID=NOP, valid=0; fetch_state=IDLE. Count unchanged.
//   6. ADDR_W=8, PC=32'hFC -> imem_addr=8'hFC, then 8'h00 with pc_current=32'h100.
//      reset during stall -> next cycle all reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: FSM state encoding, PC select and step constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StStall = 2'b01,
    StFlush = 2'b10,
    StIdle  = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    PcIncr   = 2'b00,
    PcHold   = 2'b01,
    PcTarget = 2'b10
  } pc_sel_t;

  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;

  // Redirect targets are word aligned; the low two bits of the target are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational adder, wraps modulo 2^Width.
module adder #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch control: per-edge priority decode (branch > stall > !pc_enable > normal) and fetch FSM.
// FETCH_DELAY_SLOT_EN keeps the instruction fetched alongside a taken branch instead of squashing it.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         pc_enable_i,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  output pc_sel_t      pc_sel_o,
  output logic         ifid_load_o,
  output logic         ifid_bubble_o,
  output logic         cnt_inc_o,
  output fetch_state_t state_o
);

  fetch_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_sel_o      = PcHold;
    ifid_load_o   = 1'b0;
    ifid_bubble_o = 1'b1;
    cnt_inc_o     = 1'b0;
    state_d       = state_q;

    if (branch_taken_i) begin
      // A redirect overrides any concurrent stall request.
      pc_sel_o    = PcTarget;
      ifid_load_o = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
      ifid_bubble_o = 1'b0;
      cnt_inc_o     = 1'b1;
`else
      ifid_bubble_o = 1'b1;
      cnt_inc_o     = 1'b0;
`endif
      state_d = StFlush;
    end else if (stall_i) begin
      pc_sel_o    = PcHold;
      ifid_load_o = 1'b0;
      state_d     = StStall;
    end else if (!pc_enable_i) begin
      pc_sel_o      = PcHold;
      ifid_load_o   = 1'b1;
      ifid_bubble_o = 1'b1;
      state_d       = StIdle;
    end else begin
      pc_sel_o      = PcIncr;
      ifid_load_o   = 1'b1;
      ifid_bubble_o = 1'b0;
      cnt_inc_o     = 1'b1;
      state_d       = StRun;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory addressing, IF/ID latch and saturating fetch counter.
// Optional delay-slot behaviour on taken branches is selected with FETCH_DELAY_SLOT_EN (see fetch_ctrl).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = FETCH_NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_enable,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       pc_current,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_plus_4,
  output logic              if_id_valid,
  output logic [1:0]        fetch_state,
  output logic [31:0]       fetch_count
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [31:0]  pc_plus_4;

  pc_sel_t      pc_sel;
  logic         ifid_load;
  logic         ifid_bubble;
  logic         cnt_inc;
  fetch_state_t state;

  fetch_ctrl u_fetch_ctrl (
    .clk            (clk),
    .reset          (reset),
    .pc_enable_i    (pc_enable),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .pc_sel_o       (pc_sel),
    .ifid_load_o    (ifid_load),
    .ifid_bubble_o  (ifid_bubble),
    .cnt_inc_o      (cnt_inc),
    .state_o        (state)
  );

  adder #(
    .Width (32)
  ) u_pc_adder (
    .a_i   (pc_q),
    .b_i   (PC_STEP),
    .sum_o (pc_plus_4)
  );

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (pc_sel)
      PcIncr:   pc_d = pc_plus_4;
      PcTarget: pc_d = align_word(branch_target);
      default:  pc_d = pc_q;
    endcase

    if (ifid_load) begin
      instr_d = ifid_bubble ? NOP_WORD : imem_data;
      pc4_d   = pc_plus_4;
      valid_d = !ifid_bubble;
    end

    // Debug counter sticks at all-ones rather than wrapping.
    if (cnt_inc && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address comes only from the PC register, never from stall/branch inputs.
  assign imem_addr       = pc_q[ADDR_W-1:0];
  assign pc_current      = pc_q;
  assign if_id_instr     = instr_q;
  assign if_id_pc_plus_4 = pc4_q;
  assign if_id_valid     = valid_q;
  assign fetch_state     = state;
  assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random stimulus vs a rule-level model.
module tb_fetch_stage;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_enable;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_current;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus_4;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;
  logic [1:0]  m_state;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  fetch_stage #(
    .ADDR_W   (8),
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_enable       (pc_enable),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc_current      (pc_current),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus_4 (if_id_pc_plus_4),
    .if_id_valid     (if_id_valid),
    .fetch_state     (fetch_state),
    .fetch_count     (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("pc_current", pc_current, m_pc);
    check_eq("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc[7:0]});
    check_eq("if_id_instr", if_id_instr, m_instr);
    check_eq("if_id_pc_plus_4", if_id_pc_plus_4, m_pc4);
    check_eq("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check_eq("fetch_state", {30'd0, fetch_state}, {30'd0, m_state});
    check_eq("fetch_count", fetch_count, m_cnt);
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven, then compare.
  task automatic step();
    logic [31:0] pc, instr, pc4, cnt;
    logic        valid;
    logic [1:0]  st;
    logic [31:0] word;
    pc = m_pc; instr = m_instr; pc4 = m_pc4; cnt = m_cnt; valid = m_valid; st = m_state;
    word = mem[m_pc[7:2]];
    if (reset) begin
      pc = 32'h0; instr = 32'h0; pc4 = 32'h0; valid = 1'b0; st = 2'b11; cnt = 32'h0;
    end else if (branch_taken) begin
      pc  = {branch_target[31:2], 2'b00};
      pc4 = m_pc + 32'd4;
      st  = 2'b10;
      if (DelaySlot) begin
        instr = word; valid = 1'b1; cnt = sat_inc(m_cnt);
      end else begin
        instr = 32'h0; valid = 1'b0;
      end
    end else if (stall) begin
      st = 2'b01;
    end else if (!pc_enable) begin
      instr = 32'h0; pc4 = m_pc + 32'd4; valid = 1'b0; st = 2'b11;
    end else begin
      instr = word; pc4 = m_pc + 32'd4; valid = 1'b1; cnt = sat_inc(m_cnt);
      pc = m_pc + 32'd4; st = 2'b00;
    end
    @(posedge clk);
    #1;
    m_pc = pc; m_instr = instr; m_pc4 = pc4; m_cnt = cnt; m_valid = valid; m_state = st;
    check_all();
  endtask

  task automatic drive(input logic r, input logic en, input logic st, input logic br,
                       input logic [31:0] tgt);
    reset = r; pc_enable = en; stall = st; branch_taken = br; branch_target = tgt;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0; m_valid = 0; m_state = 2'b11;

    // Reset for three cycles, then straight-line fetch
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) step();

    // Stall holds PC and IF/ID, release resumes
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();

    // Taken branch to unaligned target, then branch concurrent with stall
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0023);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0010);
    step();

    // Frontend frozen for two cycles
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();

    // Address wrap at 2^ADDR_W bytes
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00FC);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) step();

    // PC+4 wrap modulo 2^32
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step();

    // Reset during stall and during redirect
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
    step();

    // Random phase
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0),
            $urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
